// File: rtl/mat_pkg.sv
// Shared constants and FSM encoding for the matrix stream-out block.
// Element (r,c) lives at [ROW_SIZE*r + DATA_LEN*c +: DATA_LEN].
package mat_pkg;
  localparam int DATA_LEN_DEF = 32;
  localparam int M_DEF        = 8;
  localparam int K_DEF        = 8;
  localparam int ROW_SIZE_DEF = DATA_LEN_DEF * K_DEF;
  localparam int MAT_SIZE_DEF = ROW_SIZE_DEF * M_DEF;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W_DEF = idx_w(M_DEF);
  localparam int COL_W_DEF = idx_w(K_DEF);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;
endpackage

// File: rtl/mat_idx_cnt.sv
// Row-major (r,c) walker over an M x K matrix.
// Clear wins over enable so a capture always restarts at (0,0).
module mat_idx_cnt #(
  parameter int M     = 8,
  parameter int K     = 8,
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             en,
  input  logic             clr,
  output logic [ROW_W-1:0] r,
  output logic [COL_W-1:0] c,
  output logic             row_end,
  output logic             mat_end
);

  assign row_end = (c == COL_W'(K - 1));
  assign mat_end = row_end & (r == ROW_W'(M - 1));

  // advance one element per enabled cycle, wrapping at row and matrix end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r <= '0;
      c <= '0;
    end else if (clr) begin
      r <= '0;
      c <= '0;
    end else if (en) begin
      if (row_end) begin
        c <= '0;
        r <= mat_end ? '0 : r + 1'b1;
      end else begin
        c <= c + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mat_stream_out.sv
// Captures a flattened matrix and streams it one element per beat.
// MAT_LAST_FLAG_EN adds o_row_last / o_mat_last.
module mat_stream_out
  import mat_pkg::*;
#(
  parameter  int DATA_LEN = DATA_LEN_DEF,
  parameter  int M        = M_DEF,
  parameter  int K        = K_DEF,
  localparam int ROW_SIZE = DATA_LEN * K,
  localparam int MAT_SIZE = ROW_SIZE * M,
  localparam int ROW_W    = idx_w(M),
  localparam int COL_W    = idx_w(K)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [MAT_SIZE-1:0] i_mat,
  input  logic                i_mat_valid,
  output logic                o_mat_ready,
  output logic [DATA_LEN-1:0] o_elem_data,
  output logic [ROW_W-1:0]    o_elem_row,
  output logic [COL_W-1:0]    o_elem_col,
  output logic                o_elem_valid,
`ifdef MAT_LAST_FLAG_EN
  output logic                o_row_last,
  output logic                o_mat_last,
`endif
  input  logic                i_elem_ready
);

  state_t state;
  state_t state_nx;

  logic [M-1:0][K-1:0][DATA_LEN-1:0] buffer;

  logic [ROW_W-1:0] r;
  logic [COL_W-1:0] c;
  logic             row_end;
  logic             mat_end;
  logic             beat;
  logic             last_beat;
  logic             capture;

  mat_idx_cnt #(
    .M     (M),
    .K     (K),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_idx (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .en      (beat),
    .clr     (capture),
    .r       (r),
    .c       (c),
    .row_end (row_end),
    .mat_end (mat_end)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nx;
  end

  // handshakes and next state; a capture on the last beat keeps streaming
  always_comb begin
    state_nx     = state;
    o_elem_valid = 1'b0;
    beat         = 1'b0;
    last_beat    = 1'b0;
    o_mat_ready  = 1'b0;
    capture      = 1'b0;
    unique case (state)
      IDLE: begin
        o_mat_ready = 1'b1;
        capture     = i_mat_valid;
        if (capture) state_nx = STREAM;
      end
      STREAM: begin
        o_elem_valid = 1'b1;
        beat         = i_elem_ready;
        last_beat    = beat & mat_end;
        o_mat_ready  = last_beat;
        capture      = last_beat & i_mat_valid;
        if (last_beat && !capture) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // matrix buffer, loaded only on an accepted handshake
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)      buffer <= '0;
    else if (capture) buffer <= i_mat;
  end

  // element mux; idle drives zero
  always_comb begin
    o_elem_data = '0;
    if (o_elem_valid) o_elem_data = buffer[r][c];
  end

  assign o_elem_row = r;
  assign o_elem_col = c;

`ifdef MAT_LAST_FLAG_EN
  assign o_row_last = o_elem_valid & row_end;
  assign o_mat_last = o_elem_valid & mat_end;
`endif

endmodule
